iot_event_arbiter: RTL

IOT_EVENT_ARBITER -- requirements
Module: iot_event_arbiter

---
 rtl/iot_event_arbiter.sv | 68 ++++++
 1 files changed

// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter: round-robin serialiser of device on/off events into one monitor change per cycle.
// Optional EVT_FILTER_EN suppresses mon_change for events that match the current active state.
module iot_event_arbiter #(
   parameter int NUM_DEV = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_DEV-1:0] req,
   input  logic [NUM_DEV-1:0] req_on_off,
   output logic [NUM_DEV-1:0] ack,
   output logic               mon_change,
   output logic               mon_on_off,
   output logic [NUM_DEV-1:0] active,
   output logic [3:0]         active_cnt
);
   localparam int PW = $clog2(NUM_DEV);
   localparam logic [PW:0] N = NUM_DEV[PW:0];
   logic [PW-1:0]      rr_ptr, g, ptr_nxt;
   logic [PW:0]        idx;
   logic               hit, chg;
   logic [NUM_DEV-1:0] elig, active_nxt, grant;
   logic [3:0]         cnt_nxt;
   always_comb begin
      elig = req & ~ack;
      hit = 1'b0;
      g = '0;
      idx = '0;
      // scan from rr_ptr upward, wrapping at NUM_DEV; first eligible wins
      for (int i = 0; i < NUM_DEV; i++) begin
         idx = {1'b0, rr_ptr} + (PW+1)'(i);
         idx = (idx >= N) ? idx - N : idx;
         if (!hit && elig[idx]) begin
            hit = 1'b1;
            g = idx[PW-1:0];
         end
      end
      ptr_nxt = ({1'b0, g} == N - 1'b1) ? '0 : g + 1'b1;
      grant = hit ? (NUM_DEV'(1) << g) : '0;
`ifdef EVT_FILTER_EN
      chg = req_on_off[g] != active[g];
`else
      chg = 1'b1;
`endif
      active_nxt = active;
      if (hit) active_nxt[g] = req_on_off[g];
      cnt_nxt = '0;
      for (int i = 0; i < NUM_DEV; i++) cnt_nxt = cnt_nxt + 4'(active_nxt[i]);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack        <= '0;
         mon_change <= 1'b0;
         mon_on_off <= 1'b0;
         active     <= '0;
         active_cnt <= '0;
         rr_ptr     <= '0;
      end else begin
         ack        <= grant;
         mon_change <= hit && chg;
         active     <= active_nxt;
         active_cnt <= cnt_nxt;
         if (hit) begin
            mon_on_off <= req_on_off[g];
            rr_ptr     <= ptr_nxt;
         end
      end
   end
endmodule
